// File: rtl/wl_enc_pkg.sv
// Shared constants, FSM state type and popcount helper for the WL mask encoder.
package wl_enc_pkg;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned AW    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    function automatic logic [AW:0] popcount(input logic [WIDTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc128.sv
// Combinational lowest-set-bit priority encoder with any-set and one-hot flags.
module prio_enc128
    import wl_enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec_i,
    output logic [AW-1:0]    idx_o,
    output logic             any_set_o,
    output logic             one_hot_o
);

    // Scan from the top so the lowest set bit is the last to write idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = AW'(i);
            end
        end
    end

    assign any_set_o = |vec_i;
    assign one_hot_o = any_set_o && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/wl_mask_encoder.sv
// Streams the index of every set bit of a row-activity mask, lowest first.
// Optional active_cnt output enabled by WL_MASK_ENCODER_POPCNT_EN.
module wl_mask_encoder
    import wl_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_idx,
    output logic             out_last,
`ifdef WL_MASK_ENCODER_POPCNT_EN
    output logic [AW:0]      active_cnt,
`endif
    output logic             done
);

    enc_state_t       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [AW-1:0]    enc_idx;
    logic             enc_any, enc_one;

    prio_enc128 u_prio_enc (
        .vec_i     (mask_q),
        .idx_o     (enc_idx),
        .any_set_o (enc_any),
        .one_hot_o (enc_one)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN);
        out_idx   = out_valid ? enc_idx : '0;
        out_last  = out_valid && enc_one;
        done      = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = mask_in;
                    state_d = (|mask_in) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    // Clearing the lowest set bit is the same as clearing bit out_idx.
                    mask_d = mask_q & (mask_q - 1'b1);
                    if (enc_one || !enc_any) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

`ifdef WL_MASK_ENCODER_POPCNT_EN
    logic [AW:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (in_ready && in_valid) begin
            cnt_d = popcount(mask_in);
        end else if (out_valid && out_ready && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wl_mask_encoder.sv
// Table-driven, scoreboard-checked bench for wl_mask_encoder.
module tb_wl_mask_encoder;
    import wl_enc_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mask_in;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_idx;
    logic             out_last;
    logic             done;
`ifdef WL_MASK_ENCODER_POPCNT_EN
    logic [AW:0]      active_cnt;
`endif

    wl_mask_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mask_in    (mask_in),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
`ifdef WL_MASK_ENCODER_POPCNT_EN
        .active_cnt (active_cnt),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] mask;
        int               ready_mode;  // 0: held high, 1: toggles 1,0,1,0
        int               exp_n;
        int               exp_first;
        int               exp_last;
    } vec_t;

    vec_t vecs[6];
    int   sb_q[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [WIDTH-1:0] m);
        sb_q.delete();
        for (int k = 0; k < int'(WIDTH); k++) begin
            if (m[k]) sb_q.push_back(k);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        int hs;
        int first_v;
        int last_v;
        bit got_done;
        hs = 0; first_v = -1; last_v = -1; got_done = 0;
        chk("pre_load_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        mask_in  = v.mask;
        push_expected(v.mask);
        @(negedge clk);
        in_valid = 1'b0;
        mask_in  = '0;
        chk("first_cycle_valid", 128'(out_valid), 128'(v.exp_n != 0));
        chk("first_cycle_done", 128'(done), 128'(v.exp_n == 0));
        for (int c = 0; c < 400 && !got_done; c++) begin
            out_ready = (v.ready_mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("extra_index", 128'(out_idx), 128'hffff);
                end else begin
                    chk("out_idx", 128'(out_idx), 128'(sb_q[0]));
                    chk("out_last", 128'(out_last), 128'(sb_q.size() == 1));
                    if (out_ready) begin
                        if (hs == 0) first_v = int'(out_idx);
                        last_v = int'(out_idx);
                        void'(sb_q.pop_front());
                        hs++;
                    end
                end
            end
            if (done) begin
                got_done = 1;
                chk("done_without_valid", 128'(out_valid), 128'(0));
            end else begin
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        chk("done_seen", 128'(got_done), 128'(1));
        chk("handshakes", 128'(hs), 128'(v.exp_n));
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        if (v.exp_n > 0) begin
            chk("first_index", 128'(first_v), 128'(v.exp_first));
            chk("last_index", 128'(last_v), 128'(v.exp_last));
        end
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
        chk("back_to_idle", 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [WIDTH-1:0] m;
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; mask_in = '0; abort = 1'b0; out_ready = 1'b0;

        m = '0; m[3] = 1'b1; m[64] = 1'b1; m[127] = 1'b1;
        vecs[0] = '{m, 0, 3, 3, 127};
        vecs[1] = '{'0, 0, 0, 0, 0};
        vecs[2] = '{'1, 1, 128, 0, 127};
        m = '0; m[0] = 1'b1;
        vecs[3] = '{m, 0, 1, 0, 0};
        m = '0; m[127] = 1'b1;
        vecs[4] = '{m, 1, 1, 127, 127};
        m = '0; m[0] = 1'b1; m[63] = 1'b1; m[64] = 1'b1;
        vecs[5] = '{m, 1, 3, 0, 64};

        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_idx", 128'(out_idx), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
`ifdef WL_MASK_ENCODER_POPCNT_EN
        chk("rst_active_cnt", 128'(active_cnt), 128'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort on the beat presenting idx 5 of {5,9}: beat dropped, no done.
        m = '0; m[5] = 1'b1; m[9] = 1'b1;
        in_valid = 1'b1; mask_in = m;
        @(negedge clk);
        in_valid = 1'b0; mask_in = '0;
        chk("abort_pre_idx", 128'(out_idx), 128'(5));
        out_ready = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_idle", 128'(in_ready), 128'(1));
        chk("abort_no_valid", 128'(out_valid), 128'(0));
        chk("abort_no_done", 128'(done), 128'(0));
        m = '0; m[1] = 1'b1;
        run_vec('{m, 0, 1, 1, 1});

        // Abort wins over a simultaneous load.
        m = '0; m[7] = 1'b1;
        in_valid = 1'b1; mask_in = m; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mask_in = '0; abort = 1'b0;
        chk("abort_load_idle", 128'(in_ready), 128'(1));
        chk("abort_load_no_valid", 128'(out_valid), 128'(0));
        chk("abort_load_no_done", 128'(done), 128'(0));

        // Asynchronous reset in the middle of a scan.
        m = '0; m[10] = 1'b1; m[20] = 1'b1; m[30] = 1'b1;
        in_valid = 1'b1; mask_in = m;
        @(negedge clk);
        in_valid = 1'b0; mask_in = '0; out_ready = 1'b1;
        chk("scan_idx10", 128'(out_idx), 128'(10));
        @(negedge clk);
        chk("scan_idx20", 128'(out_idx), 128'(20));
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_idx", 128'(out_idx), 128'(0));
        chk("arst_out_last", 128'(out_last), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 128'(out_valid), 128'(0));
            chk("post_rst_done", 128'(done), 128'(0));
            chk("post_rst_ready", 128'(in_ready), 128'(1));
        end
        out_ready = 1'b0;

`ifdef WL_MASK_ENCODER_POPCNT_EN
        m = '0; m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; m[100] = 1'b1;
        in_valid = 1'b1; mask_in = m;
        @(negedge clk);
        in_valid = 1'b0; mask_in = '0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("active_cnt", 128'(active_cnt), 128'(4 - c));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("cnt_idle", 128'(in_ready), 128'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wl_mask_encoder.md
Name: wl_mask_encoder

Overview:
- Reverse direction of the 7-to-128 WL/BL/SL address decoder.
- Accepts a 128-bit row-activity mask, for example the nonzero-activation mask of a sparse CNN input vector.
- Emits the index of every set bit, lowest first, one index per cycle over a valid/ready stream.
- Sits between the sparsity front-end and the RRAM array address path; each emitted 7-bit index drives the decoder directly.

Parameters:
- WIDTH, 128, mask width in bits; must be a power of two.
- AW, 7, index width; must equal log2(WIDTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  mask_in is valid.
- in_ready  out  1  block can accept a new mask (state IDLE).
- mask_in  in  WIDTH  bit k set = row k is active.
- abort  in  1  synchronous flush; drops the remaining indices.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  AW  index of the lowest set bit still pending.
- out_last  out  1  out_idx is the final pending index of this mask.
- done  out  1  one-cycle pulse when a mask has been fully drained.

Interface decisions:
- One clock.
- Reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- State: mask_q (WIDTH bits) plus an FSM with states IDLE, SCAN, DONE.
- Reset, asynchronous on rst_n low:
  - FSM goes to IDLE and mask_q is cleared.
  - Outputs: in_ready=1 (IDLE), out_valid=0, out_idx=0, out_last=0, done=0.
- Reset asserted mid-SCAN discards all pending indices; no done pulse.
- in_ready = (state==IDLE).
- out_valid = (state==SCAN).
- out_idx = priority encode of mask_q, lowest set bit wins; forced to 0 when out_valid=0.
- out_last = out_valid and mask_q has exactly one bit set.
- IDLE:
  - On in_valid and in_ready: mask_q <= mask_in.
  - Next state is SCAN if mask_in is nonzero, otherwise DONE. An empty mask emits no indices and only pulses done.
- SCAN:
  - On out_valid and out_ready: clear bit out_idx in mask_q.
  - If out_last, go to DONE; otherwise stay in SCAN.
  - With out_ready low, out_idx and out_last hold stable and out_valid stays high (no drop, no reorder).
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - First index is valid the cycle after the load handshake.
  - Sustained rate is one index per cycle with out_ready held high.
  - A mask with N set bits takes N SCAN cycles plus 1 DONE cycle, so the next load can occur N+2 cycles after the previous load.
- abort:
  - In any state it forces IDLE and clears mask_q; no done pulse.
  - abort wins over a simultaneous load (mask ignored) and over a simultaneous output handshake (the beat counts as not transferred).
- Boundaries:
  - Bit 0 maps to idx 0; bit 127 maps to idx 127.
  - An all-ones mask emits 0..127 in order, with out_last only on 127.
  - Indices never wrap or repeat.

Optional Feature:
- Macro: WL_MASK_ENCODER_POPCNT_EN.
- When defined:
  - Adds output active_cnt (AW+1 bits), reset value 0.
  - Loaded with popcount(mask_in) on the load handshake.
  - Decremented on every output handshake; reaches 0 exactly when DONE is entered.
  - Cleared on abort.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package wl_enc_pkg:
  - Constants WIDTH=128 and AW=7.
  - Typedef enc_state_t {IDLE, SCAN, DONE}.
- One combinational sub-module, prio_enc128:
  - Input: WIDTH-bit vector.
  - Outputs: AW-bit index of the lowest set bit, plus any_set and one_hot (exactly one bit set).
- The FSM, mask register and handshakes stay in wl_mask_encoder.

Test Plan:
- Load mask = bits {3,64,127}, out_ready=1 → idx 3, 64, 127 on consecutive cycles; out_last only with 127; done one cycle later; in_ready high the next cycle.
- Load mask = 0 → no out_valid; done pulses the cycle after the load; back to IDLE.
- Load all-ones with out_ready toggling 1,0,1,0 → indices 0..127 with no gaps or repeats; out_idx stable while out_ready=0; 128 handshakes then done.
- Load {5,9}, then abort in the cycle idx 5 is presented with out_ready=1 → state IDLE, no done, next load {1} yields idx 1 only.
- Drop rst_n asynchronously mid-SCAN of {10,20,30} → outputs take reset values immediately; after release only in_ready=1; no residual indices.
- With WL_MASK_ENCODER_POPCNT_EN defined, load {0,1,2,100} → active_cnt=4, then 3, 2, 1, 0 across the handshakes.
